// File: rtl/acc_vec_packer.sv
// Packs a serial stream of 16-bit element pairs into 64-lane vectors (1x64, 2x32 or 4x16 rows) for the adder tree.
// Optional idle auto-flush is built when PACK_TIMEOUT_EN is defined.
module acc_vec_packer #(
  parameter int unsigned LANES   = 64,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic [DW-1:0]         i_data0,
  input  logic [DW-1:0]         i_data1,
  input  logic                  i_last,
  input  logic [3:0]            i_length_mode,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic [3:0]            o_length_mode,
  output logic [LANES*DW-1:0]   o_in0_flat,
  output logic [LANES*DW-1:0]   o_in1_flat,
  output logic [3:0]            o_row_mask,
  output logic                  o_overflow,
  output logic                  o_mode_err
);

  localparam int unsigned FW  = LANES * DW;
  localparam logic [3:0]  M16 = 4'b0001;
  localparam logic [3:0]  M32 = 4'b0010;
  localparam logic [3:0]  M64 = 4'b0100;

  typedef enum logic {EMPTY, FILL} state_t;

  state_t        state;
  logic [FW-1:0] buf0;
  logic [FW-1:0] buf1;
  logic [3:0]    mask;
  logic [3:0]    vmode;
  logic [6:0]    elem_idx;
  logic [1:0]    row_slot;
  logic          pend;

  logic          accept_c;
  logic          row_start_c;
  logic          bad_c;
  logic          old_emit_c;
  logic          drop_c;
  logic          place_c;
  logic          close_c;
  logic          full_c;
  logic          flush_c;
  logic          emit_c;
  logic          tmo_c;
  logic [3:0]    row_code_c;
  logic [3:0]    cur_mode_c;
  logic [3:0]    wmask_c;
  logic [6:0]    seg_c;
  logic [1:0]    rows_m1_c;
  logic [1:0]    slot_c;
  logic [5:0]    lane_c;
  logic [FW-1:0] wb0_c;
  logic [FW-1:0] wb1_c;

  // Placement, close and emit decisions for the current cycle.
  always_comb begin
    accept_c    = i_valid && i_en;
    row_start_c = accept_c && (elem_idx == 7'd0);
    bad_c       = 1'b0;
    row_code_c  = i_length_mode;
    case (i_length_mode)
      M16, M32, M64: bad_c = 1'b0;
      default: begin
        bad_c      = 1'b1;
        row_code_c = M64;
      end
    endcase

    cur_mode_c = row_start_c ? row_code_c : vmode;
    seg_c      = 7'd64;
    rows_m1_c  = 2'd0;
    case (cur_mode_c)
      M16: begin seg_c = 7'd16; rows_m1_c = 2'd3; end
      M32: begin seg_c = 7'd32; rows_m1_c = 2'd1; end
      default: begin seg_c = 7'd64; rows_m1_c = 2'd0; end
    endcase

    // A mode change, or a vector completed during a mode change, ships the old buffer first.
    old_emit_c = (state == FILL) && (pend || (row_start_c && (row_code_c != vmode)));
    slot_c     = old_emit_c ? 2'd0 : row_slot;
    drop_c     = accept_c && (elem_idx == seg_c);
    place_c    = accept_c && !drop_c;
    close_c    = accept_c && i_last;
    full_c     = close_c && (slot_c == rows_m1_c);
    flush_c    = i_flush || tmo_c;
    emit_c     = !old_emit_c && (full_c || (flush_c && ((state == FILL) || accept_c)));
    lane_c     = 6'(slot_c) * 6'(seg_c) + 6'(elem_idx);

    wb0_c = old_emit_c ? '0 : buf0;
    wb1_c = old_emit_c ? '0 : buf1;
    if (place_c) begin
      wb0_c[lane_c*DW +: DW] = i_data0;
      wb1_c[lane_c*DW +: DW] = i_data1;
    end
    wmask_c = (old_emit_c ? 4'b0000 : mask) | (accept_c ? (4'b0001 << slot_c) : 4'b0000);
  end

`ifdef PACK_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] idle_cnt;

  // Idle counter: fires an implicit flush on the TIMEOUT-th idle cycle of a partial vector.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idle_cnt <= '0;
    end else if (i_en) begin
      if (accept_c || emit_c || old_emit_c || (state == EMPTY)) idle_cnt <= '0;
      else                                                      idle_cnt <= idle_cnt + CW'(1);
    end
  end

  assign tmo_c = (state == FILL) && !accept_c && (idle_cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout_c;
  assign unused_timeout_c = ^TIMEOUT;
  assign tmo_c = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= EMPTY;
      buf0          <= '0;
      buf1          <= '0;
      mask          <= '0;
      vmode         <= '0;
      elem_idx      <= '0;
      row_slot      <= '0;
      pend          <= 1'b0;
      o_valid       <= 1'b0;
      o_length_mode <= '0;
      o_in0_flat    <= '0;
      o_in1_flat    <= '0;
      o_row_mask    <= '0;
      o_overflow    <= 1'b0;
      o_mode_err    <= 1'b0;
    end else if (i_en) begin
      o_valid <= emit_c || old_emit_c;
      if (old_emit_c) begin
        o_in0_flat    <= buf0;
        o_in1_flat    <= buf1;
        o_length_mode <= vmode;
        o_row_mask    <= mask;
      end else if (emit_c) begin
        o_in0_flat    <= wb0_c;
        o_in1_flat    <= wb1_c;
        o_length_mode <= cur_mode_c;
        o_row_mask    <= wmask_c;
      end
      if (drop_c)               o_overflow <= 1'b1;
      if (row_start_c && bad_c) o_mode_err <= 1'b1;

      if (emit_c) begin
        buf0     <= '0;
        buf1     <= '0;
        mask     <= '0;
        elem_idx <= '0;
        row_slot <= '0;
        pend     <= 1'b0;
        state    <= EMPTY;
      end else begin
        buf0 <= wb0_c;
        buf1 <= wb1_c;
        mask <= wmask_c;
        pend <= old_emit_c && full_c;
        if (accept_c) begin
          state <= FILL;
          vmode <= cur_mode_c;
        end else if (old_emit_c) begin
          state <= EMPTY;
        end
        if (close_c) begin
          elem_idx <= '0;
          row_slot <= full_c ? 2'd0 : slot_c + 2'd1;
        end else if (place_c) begin
          elem_idx <= elem_idx + 7'd1;
          row_slot <= slot_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_vec_packer.sv
// Directed bench for acc_vec_packer: packing modes, overflow, mode change, enable stall and flush.
module tb_acc_vec_packer;

  localparam int unsigned LANES = 64;
  localparam int unsigned DW    = 16;
  localparam int unsigned FW    = LANES * DW;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          valid = 1'b0;
  logic          last  = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] d0    = '0;
  logic [DW-1:0] d1    = '0;
  logic [3:0]    mode  = '0;

  logic          o_valid;
  logic [3:0]    o_mode;
  logic [3:0]    o_mask;
  logic [FW-1:0] in0;
  logic [FW-1:0] in1;
  logic          ovf;
  logic          merr;

  int unsigned   total = 0;
  int unsigned   bad   = 0;
  logic [FW-1:0] e0;
  logic [FW-1:0] e1;
  logic [FW-1:0] zero_v = '0;

  acc_vec_packer dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_valid       (valid),
    .i_data0       (d0),
    .i_data1       (d1),
    .i_last        (last),
    .i_length_mode (mode),
    .i_flush       (flush),
    .o_valid       (o_valid),
    .o_length_mode (o_mode),
    .o_in0_flat    (in0),
    .o_in1_flat    (in1),
    .o_row_mask    (o_mask),
    .o_overflow    (ovf),
    .o_mode_err    (merr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] a0, input logic [DW-1:0] a1, input logic l, input logic [3:0] m);
    valid = 1'b1;
    d0    = a0;
    d1    = a1;
    last  = l;
    mode  = m;
    tick();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  function automatic int unsigned lane_diff(input logic [FW-1:0] a, input logic [FW-1:0] b);
    int unsigned n = 0;
    for (int k = 0; k < LANES; k++)
      if (a[k*DW +: DW] !== b[k*DW +: DW]) n++;
    return n;
  endfunction

  initial begin
    int unsigned len [4] = '{16, 10, 16, 5};

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(o_valid), 0);
    check("rst_mode", 32'(o_mode), 0);
    check("rst_mask", 32'(o_mask), 0);
    check("rst_flags", {30'd0, ovf, merr}, 0);
    check("rst_in1", lane_diff(in1, zero_v), 0);
    rst_n = 1'b1;
    en    = 1'b1;
    tick();

    // 64-mode full row
    e0 = '0; e1 = '0;
    for (int k = 0; k < 64; k++) begin
      e0[k*DW +: DW] = 16'(100 + k);
      e1[k*DW +: DW] = 16'(k);
      send(16'(100 + k), 16'(k), k == 63, 4'b0100);
      if (k == 62) check("m64_early_valid", 32'(o_valid), 0);
    end
    check("m64_valid", 32'(o_valid), 1);
    check("m64_in1", lane_diff(in1, e1), 0);
    check("m64_in0", lane_diff(in0, e0), 0);
    check("m64_mode", 32'(o_mode), 32'h4);
    check("m64_mask", 32'(o_mask), 32'h1);
    tick();
    check("m64_single_beat", 32'(o_valid), 0);

    // 16-mode, rows of 16/10/16/5
    e0 = '0; e1 = '0;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < int'(len[r]); j++) begin
        e0[(r*16 + j)*DW +: DW] = 16'd2;
        e1[(r*16 + j)*DW +: DW] = 16'd1;
        send(16'd2, 16'd1, j == int'(len[r]) - 1, 4'b0001);
        if (r == 2 && j == 15) check("m16_partial_valid", 32'(o_valid), 0);
      end
    check("m16_valid", 32'(o_valid), 1);
    check("m16_in1", lane_diff(in1, e1), 0);
    check("m16_in0", lane_diff(in0, e0), 0);
    check("m16_mask", 32'(o_mask), 32'hf);
    check("m16_mode", 32'(o_mode), 32'h1);

    // 32-mode row of 8, then a 64-mode row start forces an emit
    e1 = '0;
    for (int j = 0; j < 8; j++) begin
      e1[j*DW +: DW] = 16'(10 + j);
      send(16'd0, 16'(10 + j), j == 7, 4'b0010);
    end
    check("m32_no_beat", 32'(o_valid), 0);
    send(16'd0, 16'h55, 1'b0, 4'b0100);
    check("chg_valid", 32'(o_valid), 1);
    check("chg_mode", 32'(o_mode), 32'h2);
    check("chg_mask", 32'(o_mask), 32'h1);
    check("chg_in1", lane_diff(in1, e1), 0);
    send(16'd0, 16'h56, 1'b0, 4'b0100);
    check("chg_gap", 32'(o_valid), 0);
    send(16'd0, 16'h57, 1'b1, 4'b0100);
    e1 = '0;
    e1[0*DW +: DW] = 16'h55;
    e1[1*DW +: DW] = 16'h56;
    e1[2*DW +: DW] = 16'h57;
    check("new_valid", 32'(o_valid), 1);
    check("new_mode", 32'(o_mode), 32'h4);
    check("new_in1", lane_diff(in1, e1), 0);
    check("pre_ovf", 32'(ovf), 0);

    // 16-mode overflow: 20 elements, next row lands at lane 16
    e1 = '0;
    for (int j = 0; j < 20; j++) begin
      if (j < 16) e1[j*DW +: DW] = 16'(200 + j);
      send(16'd0, 16'(200 + j), j == 19, 4'b0001);
    end
    check("ovf_set", 32'(ovf), 1);
    for (int j = 0; j < 3; j++) begin
      e1[(16 + j)*DW +: DW] = 16'(300 + j);
      send(16'd0, 16'(300 + j), j == 2, 4'b0001);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("ovf_valid", 32'(o_valid), 1);
    check("ovf_in1", lane_diff(in1, e1), 0);
    check("ovf_mask", 32'(o_mask), 32'h3);
    check("ovf_mode", 32'(o_mode), 32'h1);

    // Enable stall mid-row and while a beat is on the output
    e1 = '0;
    for (int j = 0; j < 4; j++) begin
      e1[j*DW +: DW] = 16'(j + 1);
      send(16'd0, 16'(j + 1), 1'b0, 4'b0100);
    end
    en    = 1'b0;
    valid = 1'b1;
    d1    = 16'hdead;
    for (int c = 0; c < 5; c++) tick();
    valid = 1'b0;
    en    = 1'b1;
    check("stall_no_beat", 32'(o_valid), 0);
    for (int j = 4; j < 8; j++) begin
      e1[j*DW +: DW] = 16'(j + 1);
      send(16'd0, 16'(j + 1), j == 7, 4'b0100);
    end
    check("stall_valid", 32'(o_valid), 1);
    check("stall_in1", lane_diff(in1, e1), 0);
    en = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("hold_valid", 32'(o_valid), 1);
    check("hold_in1", lane_diff(in1, e1), 0);
    en = 1'b1;
    tick();
    check("hold_release", 32'(o_valid), 0);

    // Partial vector flush, then flush while empty
    e1 = '0;
    for (int j = 0; j < 3; j++) begin
      e1[j*DW +: DW] = 16'd7;
      send(16'd8, 16'd7, 1'b0, 4'b0001);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid", 32'(o_valid), 1);
    check("fl_in1", lane_diff(in1, e1), 0);
    check("fl_mask", 32'(o_mask), 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_empty", 32'(o_valid), 0);

    // Illegal mode code behaves as 64-mode and sets the sticky error
    check("pre_merr", 32'(merr), 0);
    send(16'd0, 16'h99, 1'b1, 4'b0011);
    check("bad_valid", 32'(o_valid), 1);
    check("bad_mode", 32'(o_mode), 32'h4);
    check("merr_set", 32'(merr), 1);
    tick();
    check("ovf_sticky", 32'(ovf), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
